queue_enq_arbiter: RTL and testbench
====================================

// Module: queue_enq_arbiter
// PURPOSE
//  Round-robin arbiter sharing one queue enqueue port among NUM_REQ producers.
//  Per-requester outstanding-entry credit limit stops any one producer from filling the queue.
//  Registered output stage drives the queue enq/din side directly.
//  Queue consumer reports each dequeue by tag so the owning requester's credit returns.
// PARAMETERS
//  NUM_REQ          4   number of requesters, >=2
//  DATA_W           4   payload width, matches queue din
//  MAX_OUTSTANDING  2   max entries one requester may hold in the queue, >=1
// PORTS
//  clk        in   1                    clock, rising edge
//  reset      in   1                    async reset, ACTIVE-LOW (0 = reset)
//  req_valid  in   NUM_REQ              per-requester valid
//  req_data   in   NUM_REQ*DATA_W       payload; requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ              one-hot grant; transfer when req_valid[i]&&req_ready[i]
//  out_valid  out  1                    to queue enq
//  out_data   out  DATA_W               to queue din
//  out_tag    out  clog2(NUM_REQ)       owning requester of out_data
//  out_ready  in   1                    from queue enq_ready
//  rel_valid  in   1                    one entry dequeued from queue
//  rel_tag    in   clog2(NUM_REQ)       owner of the dequeued entry
//  err        out  1                    sticky protocol-error flag
// BEHAVIOUR
//  Reset asserted (reset=0), asynchronously:
//    out_valid=0, out_data=0, out_tag=0, err=0, all credit counters=0, rr_ptr=0.
//    req_ready=0 for the whole time reset is low.
//  load = !out_valid || out_ready (output register free or draining this cycle).
//  eligible[i] = req_valid[i] && cnt[i] < MAX_OUTSTANDING. Use the pre-edge cnt.
//  Grant:
//    First eligible index scanning rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
//    req_ready[g]=1 only when load && an eligible index exists.
//    req_ready is combinational from the above; never more than one bit set.
//  On grant, at the clock edge:
//    out_data <= req_data[g], out_tag <= g, out_valid <= 1.
//    cnt[g] += 1.
//    rr_ptr <= (g+1) mod NUM_REQ.
//  No grant and out_ready=1: out_valid <= 0. rr_ptr and output data hold.
//  out_valid=1 && out_ready=0: out_data and out_tag hold stable.
//  Latency: request accepted in cycle N -> out_valid in cycle N+1. Full throughput, 1 grant/cycle.
//  Release (rel_valid=1):
//    cnt[rel_tag] -= 1.
//    Grant and release on the same tag in one cycle: net no change.
//    Eligibility that cycle still uses the old count; a freed credit is usable next cycle.
//  Errors: err <= 1, sticky until reset, and the counter is left unchanged when:
//    rel_valid with rel_tag >= NUM_REQ;
//    rel_valid with cnt[rel_tag]==0 and no same-cycle grant to that tag.
//  cnt width clog2(MAX_OUTSTANDING+1). It can never exceed MAX_OUTSTANDING.
//  Reset mid-operation: any pending out_valid entry is dropped. The queue is expected to be reset alongside.
// TESTING  (NUM_REQ=4, DATA_W=4, MAX_OUTSTANDING=2)
//  1. reset=0 with req_valid=1111 -> req_ready=0000, out_valid=0, err=0.
//     Release reset -> first grant goes to req 0.
//  2. req_valid=1111, data i=i+1, out_ready=1, one release per output cycle:
//     out_tag sequence 0,1,2,3,0 and out_data 1,2,3,4,1 on consecutive cycles.
//  3. out_valid=1, out_data=5, out_ready=0 for 3 cycles -> req_ready=0000 and out_data stays 5.
//     out_ready=1 -> next grant on the following edge.
//  4. Only req_valid[0]=1, no release -> two grants, then req_ready[0]=0 and out_valid drops.
//     rel_valid=1, rel_tag=0 -> req_ready[0]=1 on the next cycle.
//  5. cnt[1]=2: grant tag 1 blocked.
//     cnt[1]=1 with same-cycle grant to 1 and release tag 1 -> cnt[1] stays 1, err=0.
//  6. rel_valid=1, rel_tag=2 with cnt[2]=0 -> err=1 and stays 1.
//     Pulse reset=0 mid-stream -> err=0, out_valid=0 immediately.

Source files
------------

// File: rtl/queue_enq_arbiter.sv
// Round-robin arbiter sharing one queue enqueue port among NUM_REQ producers,
// with per-requester outstanding-entry credits returned by tagged dequeue reports.

module queue_enq_credit #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic credit_ok,
    output logic underflow
);
    logic [CNT_W-1:0] cnt;

    assign credit_ok = cnt < CNT_W'(MAX_OUTSTANDING);
    // A release with a same-cycle grant to this tag nets out, so it is never an underflow.
    assign underflow = dec && !inc && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + CNT_W'(1);
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end
endmodule

module queue_enq_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_W          = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_tag,
    input  logic                      out_ready,
    input  logic                      rel_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rel_tag,
    output logic                      err
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic               load;
    logic               tag_bad;
    logic [NUM_REQ-1:0] credit_ok;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] dec;
    logic [NUM_REQ-1:0] underflow;

    assign load    = !out_valid || out_ready;
    assign tag_bad = rel_valid && ({1'b0, rel_tag} >= (TAG_W+1)'(NUM_REQ));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_credit
            assign dec[gi]      = rel_valid && !tag_bad && (rel_tag == TAG_W'(gi));
            assign eligible[gi] = req_valid[gi] && credit_ok[gi];

            queue_enq_credit #(
                .MAX_OUTSTANDING (MAX_OUTSTANDING),
                .CNT_W           (CNT_W)
            ) u_credit (
                .clk       (clk),
                .reset     (reset),
                .inc       (req_ready[gi]),
                .dec       (dec[gi]),
                .credit_ok (credit_ok[gi]),
                .underflow (underflow[gi])
            );
        end
    endgenerate

    // Scan from rr_ptr upward with wrap; first eligible index wins.
    always_comb begin
        int scan;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_found && eligible[scan]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(scan);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && load && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            rr_ptr    <= '0;
        end else if (load && gnt_found) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            out_tag   <= gnt_idx;
            rr_ptr    <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + TAG_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (tag_bad || (|underflow))
            err <= 1'b1;
    end
endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed bench for queue_enq_arbiter (4 requesters, 4-bit data, 2 credits each).

module tb_queue_enq_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_tag;
    logic        out_ready;
    logic        rel_valid;
    logic [1:0]  rel_tag;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    queue_enq_arbiter #(.NUM_REQ(4), .DATA_W(4), .MAX_OUTSTANDING(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .rel_valid (rel_valid),
        .rel_tag   (rel_tag),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int exp_tag  [5] = '{0, 1, 2, 3, 0};
    int exp_data [5] = '{1, 2, 3, 4, 1};

    initial begin
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 16'h4321;
        out_ready = 1'b1;
        rel_valid = 1'b0;
        rel_tag   = 2'd0;

        // reset held low with all requests valid
        step(); step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_oval",  32'(out_valid), 32'h0);
        chk("rst_odata", 32'(out_data),  32'h0);
        chk("rst_err",   32'(err),       32'h0);

        reset = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);

        // round robin, releasing each entry as it is dequeued
        for (int k = 0; k < 5; k++) begin
            rel_valid = (k > 0);
            rel_tag   = (k > 0) ? 2'(exp_tag[k-1]) : 2'd0;
            step();
            chk("rr_oval", 32'(out_valid), 32'h1);
            chk("rr_tag",  32'(out_tag),   32'(exp_tag[k]));
            chk("rr_data", 32'(out_data),  32'(exp_data[k]));
        end

        // load data 5 from req 1, then stall the output
        req_valid = 4'b0010;
        req_data  = 16'h4351;
        rel_valid = 1'b1;
        rel_tag   = 2'd0;
        step();
        chk("d5_data", 32'(out_data), 32'h5);
        chk("d5_tag",  32'(out_tag),  32'h1);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        rel_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'h0);
            step();
            chk("stall_data", 32'(out_data), 32'h5);
            chk("stall_oval", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        rel_valid = 1'b1;
        rel_tag   = 2'd1;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'b0100);
        step();
        chk("unstall_tag",  32'(out_tag),  32'h2);
        chk("unstall_data", 32'(out_data), 32'h3);

        // credit limit on req 0 (tag 2 entry released on the first cycle)
        req_valid = 4'b0001;
        rel_valid = 1'b1;
        rel_tag   = 2'd2;
        #1;
        chk("lim_ready0", 32'(req_ready), 32'b0001);
        step();
        rel_valid = 1'b0;
        #1;
        chk("lim_ready1", 32'(req_ready), 32'b0001);
        step();
        chk("lim_tag", 32'(out_tag), 32'h0);
        #1;
        chk("lim_block", 32'(req_ready), 32'h0);
        step();
        chk("lim_drop", 32'(out_valid), 32'h0);
        rel_valid = 1'b1;
        rel_tag   = 2'd0;
        #1;
        chk("lim_relcyc", 32'(req_ready), 32'h0);
        step();
        rel_valid = 1'b0;
        #1;
        chk("lim_freed", 32'(req_ready), 32'b0001);
        step();
        chk("lim_regrant", 32'(out_valid), 32'h1);

        // req 1 to its limit, then same-cycle grant+release nets zero
        req_valid = 4'b0010;
        step(); step();
        #1;
        chk("c1_block", 32'(req_ready), 32'h0);
        step();
        rel_valid = 1'b1;
        rel_tag   = 2'd1;
        step();
        #1;
        chk("c1_eligible", 32'(req_ready), 32'b0010);
        step();
        chk("c1_err", 32'(err), 32'h0);
        chk("c1_tag", 32'(out_tag), 32'h1);
        rel_valid = 1'b0;
        #1;
        chk("c1_still1", 32'(req_ready), 32'b0010);
        step();
        #1;
        chk("c1_full", 32'(req_ready), 32'h0);

        // underflow release on tag 2
        req_valid = 4'b0000;
        rel_valid = 1'b1;
        rel_tag   = 2'd2;
        step();
        chk("uf_err", 32'(err), 32'h1);
        rel_valid = 1'b0;
        step(); step();
        chk("uf_sticky", 32'(err), 32'h1);
        req_valid = 4'b0100;
        step();
        chk("pre_rst_oval", 32'(out_valid), 32'h1);

        // mid-stream reset pulse
        reset = 1'b0;
        #1;
        chk("mrst_oval",  32'(out_valid), 32'h0);
        chk("mrst_err",   32'(err),       32'h0);
        chk("mrst_ready", 32'(req_ready), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("post_rst_ready2", 32'(req_ready), 32'b0100);
        req_valid = 4'b0001;
        #1;
        chk("post_rst_cnt0", 32'(req_ready), 32'b0001);
        step();
        chk("post_rst_tag",  32'(out_tag),  32'h0);
        chk("post_rst_data", 32'(out_data), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
